weight_update_sequencer: RTL and testbench
==========================================

Name: weight_update_sequencer

Overview:
- Owns a neuron's weight bank and performs one back-propagation pass over it.
- On `start`, latches the error term and learning-rate ratio, then streams each stored weight to the downstream combinational weight-update stage.
- Writes each returned new weight back into the bank, one weight per cycle.
- Acts both as the feeder of that stage (`w`, `bp`, `tm`, `td`) and as the consumer of its result (`wn`).

Parameters:
- N_WEIGHTS, 8, number of weights in the bank (≥2).
- IDX_W, $clog2(N_WEIGHTS), index width.
- INIT_WEIGHT, 32'h0000_0100, reset value of every bank entry.
- W_MAX, 32'h7FFF_FFFF, signed upper clamp (used only with the macro).
- W_MIN, 32'h8000_0000, signed lower clamp (used only with the macro).

Ports:
- clk  in  1  sole clock; one clock domain, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a pass; sampled only in IDLE.
- bp_in  in  32  signed error term for this pass.
- tm_in  in  32  learning-rate numerator.
- td_in  in  32  learning-rate denominator.
- busy  out  1  high in LOAD/UPDATE/DONE.
- done  out  1  one-cycle pulse at pass end.
- div_err  out  1  sticky; set when a pass is aborted because td == 0; cleared by the next accepted start or by rst.
- wu_w  out  32  current weight to the update stage.
- wu_bp  out  32  latched bp.
- wu_tm  out  32  latched tm.
- wu_td  out  32  latched td.
- wu_wn  in  32  new weight from the stage, valid combinationally the same cycle.
- rd_addr  in  IDX_W  neuron-side read index.
- rd_data  out  32  bank[rd_addr], combinational.

Behaviour:
- Reset values:
  - state = IDLE, idx = 0.
  - every bank entry = INIT_WEIGHT.
  - busy = 0, done = 0, div_err = 0.
  - wu_bp, wu_tm, wu_td = 0.
  - wu_w = bank[0].
- FSM:
  - IDLE: `start` = 1 → latch bp/tm/td into wu_* regs, clear div_err, go to LOAD. Otherwise hold.
  - LOAD: if wu_td == 0 → set div_err, go to DONE, no writes. Else idx = 0, go to UPDATE.
  - UPDATE: wu_w = bank[idx]. On each edge, bank[idx] ← wu_wn and idx increments. When idx == N_WEIGHTS-1 on that edge → go to DONE, idx = 0.
  - DONE: done = 1 for exactly this cycle; next state IDLE.
- Latency: start sampled at edge E → LOAD cycle → N_WEIGHTS UPDATE cycles → done high in cycle E+N_WEIGHTS+2; busy low the following cycle.
- `start` outside IDLE is ignored (no queueing). bp_in/tm_in/td_in changes after the latch edge have no effect.
- idx never exceeds N_WEIGHTS-1; there is no wrap beyond the pass.
- rd_data reflects the bank at all times, including mid-pass. Reading the entry being written returns the old value until the write edge.
- rst asserted mid-pass returns to IDLE and restores all entries to INIT_WEIGHT. Partial updates are discarded; done is not pulsed.
- Arithmetic: bank entries are 32-bit signed and written as received. No width change.

Optional Feature:
- Macro: WU_CLAMP_EN.
- Defined: the written value is min(max(wu_wn, W_MIN), W_MAX), compared as signed.
- Undefined: wu_wn is written unmodified, and W_MAX/W_MIN are unused.

Decomposition:
- Package wu_pkg holds:
  - enum wu_state_t {IDLE, LOAD, UPDATE, DONE}.
  - typedef logic signed [31:0] weight_t.
  - localparam INIT_WEIGHT_DEFAULT.
- Sub-module weight_bank:
  - N_WEIGHTS × 32 register array.
  - synchronous write (we, waddr, wdata), asynchronous read port, synchronous reset to INIT_WEIGHT.
  - The sequencer drives one read port for wu_w and exposes a second read port as rd_addr/rd_data.

Test Plan (bench models the update stage as wn = w + bp·tm/td):
- Reset, then read addr 0..7 → all 32'h0000_0100; busy = 0, done = 0.
- start with bp = 4, tm = 1, td = 2 → done exactly 10 cycles after the start edge; every entry reads 32'h0000_0102.
- start with td = 0 → div_err = 1, done pulses after 2 cycles, bank unchanged. Next valid start clears div_err.
- start re-pulsed during UPDATE with bp = 100 → ignored; result matches a single pass with the original bp.
- rst asserted on the 3rd UPDATE cycle → bank back to 32'h0000_0100, state IDLE, no done pulse.
- WU_CLAMP_EN defined, W_MAX = 32'h0000_0180, bp = 512, tm = td = 1 → all entries read 32'h0000_0180.

Source files
------------

// File: rtl/weight_update_sequencer_pkg.sv
// Shared types for the weight update sequencer: FSM states, weight type, reset weight.
package wu_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} wu_state_t;

  typedef logic signed [31:0] weight_t;

  localparam weight_t INIT_WEIGHT_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/weight_update_sequencer_if.sv
// Link between the sequencer (master) and the combinational weight-update stage (slave).
interface weight_update_sequencer_if;
  import wu_pkg::*;

  weight_t wu_w;
  weight_t wu_bp;
  weight_t wu_tm;
  weight_t wu_td;
  weight_t wu_wn;

  modport master (output wu_w, wu_bp, wu_tm, wu_td, input wu_wn);
  modport slave  (input wu_w, wu_bp, wu_tm, wu_td, output wu_wn);

endinterface

// File: rtl/weight_update_sequencer_bank.sv
// Weight register bank: one synchronous write port, two asynchronous read ports,
// synchronous reset of every entry to INIT_WEIGHT.
module weight_bank
  import wu_pkg::*;
#(
  parameter int      N_WEIGHTS   = 8,
  parameter int      IDX_W       = $clog2(N_WEIGHTS),
  parameter weight_t INIT_WEIGHT = INIT_WEIGHT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  weight_t          wdata,
  input  logic [IDX_W-1:0] raddr_a,
  output weight_t          rdata_a,
  input  logic [IDX_W-1:0] raddr_b,
  output weight_t          rdata_b
);

  weight_t mem [N_WEIGHTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WEIGHTS; i++) begin
        mem[i] <= INIT_WEIGHT;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/weight_update_sequencer.sv
// Runs one back-propagation pass over a neuron's weight bank through an external update stage.
// Optional build macro WU_CLAMP_EN: saturate written weights to [W_MIN, W_MAX] (signed).
module weight_update_sequencer
  import wu_pkg::*;
#(
  parameter int      N_WEIGHTS   = 8,
  parameter int      IDX_W       = $clog2(N_WEIGHTS),
  parameter weight_t INIT_WEIGHT = INIT_WEIGHT_DEFAULT,
  parameter weight_t W_MAX       = 32'h7FFF_FFFF,
  parameter weight_t W_MIN       = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  weight_t                    bp_in,
  input  weight_t                    tm_in,
  input  weight_t                    td_in,
  output logic                       busy,
  output logic                       done,
  output logic                       div_err,
  weight_update_sequencer_if.master  wu,
  input  logic [IDX_W-1:0]           rd_addr,
  output weight_t                    rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WEIGHTS - 1);

  wu_state_t        state;
  logic [IDX_W-1:0] idx;
  weight_t          bp_q;
  weight_t          tm_q;
  weight_t          td_q;
  weight_t          wdata;
  weight_t          cur_w;
  logic             we;

  assign we       = (state == UPDATE);
  assign wu.wu_w  = cur_w;
  assign wu.wu_bp = bp_q;
  assign wu.wu_tm = tm_q;
  assign wu.wu_td = td_q;

`ifdef WU_CLAMP_EN
  always_comb begin
    wdata = wu.wu_wn;
    if (wu.wu_wn > W_MAX) begin
      wdata = W_MAX;
    end else if (wu.wu_wn < W_MIN) begin
      wdata = W_MIN;
    end
  end
`else
  assign wdata = wu.wu_wn;
`endif

  // Entering DONE and raising done share an edge, so done covers exactly the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div_err <= 1'b0;
      bp_q    <= '0;
      tm_q    <= '0;
      td_q    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bp_q    <= bp_in;
            tm_q    <= tm_in;
            td_q    <= td_in;
            div_err <= 1'b0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (td_q == '0) begin
            div_err <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx   <= '0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  weight_bank #(
    .N_WEIGHTS   (N_WEIGHTS),
    .IDX_W       (IDX_W),
    .INIT_WEIGHT (INIT_WEIGHT)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (idx),
    .wdata   (wdata),
    .raddr_a (idx),
    .rdata_a (cur_w),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Directed bench for weight_update_sequencer; the update stage is modelled as wn = w + bp*tm/td.
module tb_weight_update_sequencer;
  import wu_pkg::*;

  localparam int N = 8;
`ifdef WU_CLAMP_EN
  localparam weight_t TB_W_MAX   = 32'h0000_0180;
  localparam weight_t BIG_RESULT = 32'h0000_0180;
`else
  localparam weight_t TB_W_MAX   = 32'h7FFF_FFFF;
  localparam weight_t BIG_RESULT = 32'h0000_0300;
`endif

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     start = 1'b0;
  weight_t  bp_in = '0;
  weight_t  tm_in = '0;
  weight_t  td_in = '0;
  logic     busy;
  logic     done;
  logic     div_err;
  logic [2:0] rd_addr = '0;
  weight_t  rd_data;

  int checks = 0;
  int failures = 0;

  weight_update_sequencer_if wu_bus ();

  assign wu_bus.wu_wn = wu_bus.wu_w +
    ((wu_bus.wu_td == 0) ? 32'sd0 : (wu_bus.wu_bp * wu_bus.wu_tm) / wu_bus.wu_td);

  weight_update_sequencer #(
    .N_WEIGHTS (N),
    .W_MAX     (TB_W_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bp_in   (bp_in),
    .tm_in   (tm_in),
    .td_in   (td_in),
    .busy    (busy),
    .done    (done),
    .div_err (div_err),
    .wu      (wu_bus.master),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge; returns at the falling edge of the LOAD cycle (cycle 1).
  task automatic applyStimulus(input weight_t bp, input weight_t tm, input weight_t td);
    @(negedge clk);
    start = 1'b1;
    bp_in = bp;
    tm_in = tm;
    td_in = td;
    @(negedge clk);
    start = 1'b0;
    bp_in = '0;
    tm_in = '0;
    td_in = '0;
  endtask

  task automatic readAll(input string tag, input weight_t exp);
    for (int i = 0; i < N; i++) begin
      rd_addr = i[2:0];
      #1;
      checkOutput($sformatf("%s[%0d]", tag, i), rd_data, exp);
    end
    rd_addr = '0;
  endtask

  // Counts cycles from the start edge until done; optionally re-pulses start with bp=100.
  task automatic runToDone(input int poke_cyc, output int done_cyc);
    int cyc;
    cyc = 1;
    done_cyc = 0;
    while (cyc < 40) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
      if (cyc == poke_cyc) begin
        start = 1'b1;
        bp_in = 32'sd100;
        tm_in = 32'sd1;
        td_in = 32'sd2;
      end else begin
        start = 1'b0;
        bp_in = '0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int dc;
    int done_seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    readAll("reset_bank", 32'h0000_0100);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_div_err", div_err, 0);
    checkOutput("reset_wu_bp", wu_bus.wu_bp, 0);
    checkOutput("reset_wu_w", wu_bus.wu_w, 32'h0000_0100);

    applyStimulus(32'sd4, 32'sd1, 32'sd2);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_wu_bp", wu_bus.wu_bp, 32'd4);
    runToDone(0, dc);
    checkOutput("pass1_latency", dc, 10);
    @(negedge clk);
    checkOutput("pass1_busy_after", busy, 0);
    checkOutput("pass1_done_after", done, 0);
    readAll("pass1_bank", 32'h0000_0102);

    applyStimulus(32'sd4, 32'sd1, 32'sd0);
    runToDone(0, dc);
    checkOutput("div0_latency", dc, 2);
    checkOutput("div0_err", div_err, 1);
    @(negedge clk);
    checkOutput("div0_err_sticky", div_err, 1);
    readAll("div0_bank", 32'h0000_0102);

    applyStimulus(32'sd2, 32'sd1, 32'sd1);
    checkOutput("div0_err_cleared", div_err, 0);
    runToDone(0, dc);
    checkOutput("pass2_latency", dc, 10);
    @(negedge clk);
    readAll("pass2_bank", 32'h0000_0104);

    applyStimulus(32'sd4, 32'sd1, 32'sd2);
    runToDone(4, dc);
    checkOutput("restart_latency", dc, 10);
    checkOutput("restart_wu_bp", wu_bus.wu_bp, 32'd4);
    @(negedge clk);
    checkOutput("restart_busy_after", busy, 0);
    readAll("restart_bank", 32'h0000_0106);

    applyStimulus(32'sd4, 32'sd1, 32'sd2);
    @(negedge clk);
    rd_addr = 3'd0;
    #1;
    checkOutput("write_old_value", rd_data, 32'h0000_0106);
    @(negedge clk);
    #1;
    checkOutput("midpass_written", rd_data, 32'h0000_0108);
    rd_addr = 3'd2;
    #1;
    checkOutput("midpass_unwritten", rd_data, 32'h0000_0106);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wu_w", wu_bus.wu_w, 32'h0000_0100);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    checkOutput("rst_no_done", done_seen, 0);
    checkOutput("rst_idle_busy", busy, 0);
    readAll("rst_bank", 32'h0000_0100);

    applyStimulus(32'sd512, 32'sd1, 32'sd1);
    runToDone(0, dc);
    checkOutput("big_latency", dc, 10);
    @(negedge clk);
    readAll("big_bank", BIG_RESULT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
